voltage_descaler: RTL and testbench
===================================

Name: voltage_descaler

Overview:
- Inverse of the ADC voltage scaling path: converts a millivolt value (0..VREF_MV) back into a CODE_W-bit converter code.
- Used for user threshold entry, DAC setpoints and self-check against raw channel data.
- Rounded result: code = floor((mv·2^CODE_W + VREF_MV/2) / VREF_MV), saturated to 2^CODE_W−1.
- Uses a serial restoring divider (one quotient bit per clock) behind valid/ready handshakes on input and output.

Parameters:
- MV_W, 12, width of millivolt input.
- CODE_W, 12, width of output code.
- VREF_MV, 3300, full-scale reference in mV; legal range 1..2^MV_W−2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_mv  input  MV_W  requested voltage in mV.
- in_valid  input  1  in_mv is valid.
- in_ready  output  1  block can accept a request.
- out_code  output  CODE_W  converted code; stable while out_valid=1.
- out_sat  output  1  request was clamped (in_mv > VREF_MV, or rounded quotient reached 2^CODE_W).
- out_valid  output  1  out_code/out_sat valid.
- out_ready  input  1  consumer accepts result.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; in_ready=0 while rst is asserted and 1 after release; out_valid=0, out_code=0, out_sat=0; divider registers cleared.
- FSM states: IDLE, DIV, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge k: latch mv_c=min(in_mv,VREF_MV) and sat_req=(in_mv>VREF_MV).
  - Load numerator N = mv_c·2^CODE_W + floor(VREF_MV/2), width NUM_W = MV_W+CODE_W.
  - Clear remainder and counter; go to DIV.
- DIV:
  - in_ready=0.
  - Each cycle: shift remainder left one bit, take in the MSB of N, subtract VREF_MV if remainder ≥ VREF_MV, shift in one quotient bit.
  - Exactly NUM_W cycles (edges k+1..k+NUM_W), then go to DONE.
- DONE:
  - Entered at edge k+NUM_W+1 (k+25 with defaults); out_valid=1 from that edge.
  - out_code = (q ≥ 2^CODE_W) ? 2^CODE_W−1 : q[CODE_W−1:0].
  - out_sat = sat_req | (q ≥ 2^CODE_W).
  - Holds until out_valid&&out_ready, then returns to IDLE and clears out_valid on that edge.
- Latency: fixed at NUM_W+1 edges from acceptance to out_valid, independent of data, including saturated requests.
- Throughput: at most one request per NUM_W+2 cycles; no overlap and no input buffering.
- Handshakes:
  - in_ready is combinationally (state==IDLE).
  - out_valid is never withdrawn before out_ready.
  - out_code/out_sat do not change while out_valid=1.
  - in_valid asserted during DIV/DONE is ignored, never queued.
- Back-pressure: out_ready held low keeps DONE indefinitely, with results stable.
- Simultaneous events: in IDLE, out_ready is ignored; no same-cycle accept-and-deliver.
- Reset mid-operation: any state → IDLE immediately; the partial result is discarded and no out_valid pulse is produced.
- Width rules:
  - Remainder width = clog2(VREF_MV)+1.
  - Quotient width = CODE_W+1 (the extra bit detects 2^CODE_W).
  - No truncation of N is allowed for legal parameters.

Decomposition:
- Shared package voltage_pkg:
  - VREF_MV, MV_W, CODE_W defaults, plus NUM_W.
  - FSM state enum {IDLE, DIV, DONE}.
  - Reference rounding function for the bench scoreboard.
- One natural sub-module: serial_divider (start/busy/done, dividend, divisor, quotient, remainder). Generic, reusable for averaging elsewhere.

Test Plan:
- Reset, then in_mv=0 accepted at edge k → out_valid rises at edge k+25; out_code=0, out_sat=0.
- in_mv=1000 → out_code=1241. in_mv=1650 → 2048. in_mv=1 → 1. in_mv=3299 → 4095, sat=0.
- in_mv=3300 → out_code=4095, out_sat=1 (quotient 4096 clamped). in_mv=4000 → 4095, out_sat=1, same 25-edge latency.
- Hold out_ready=0 for 50 cycles after out_valid → out_code stable, in_ready=0; a new in_valid during this is ignored. Raise out_ready → next-cycle IDLE, in_ready=1.
- Assert rst low at DIV cycle 10 → out_valid stays 0, state IDLE; after release, in_mv=2500 → out_code=3103.
- Random sweep over 0..4095 with random in_valid/out_ready gaps → every result matches the package reference function; transaction count in equals out.

Source files
------------

// File: rtl/voltage_pkg.sv
// Shared defaults, FSM state type and a behavioural rounding reference for the voltage descaler.
package voltage_pkg;

  localparam int unsigned MV_W_DEF    = 12;
  localparam int unsigned CODE_W_DEF  = 12;
  localparam int unsigned VREF_MV_DEF = 3300;
  localparam int unsigned NUM_W_DEF   = MV_W_DEF + CODE_W_DEF;

  typedef enum logic [1:0] {
    StIdle,
    StDiv,
    StDone
  } state_e;

  // Returns {sat, code} for the default parameter set, using plain integer arithmetic.
  function automatic logic [CODE_W_DEF:0] ref_descale(input int unsigned mv);
    longint unsigned mv_c;
    longint unsigned q;
    logic            sat;
    logic [CODE_W_DEF-1:0] code;
    mv_c = (mv > VREF_MV_DEF) ? longint'(VREF_MV_DEF) : longint'(mv);
    q    = (mv_c * (longint'(1) << CODE_W_DEF) + longint'(VREF_MV_DEF / 2)) / VREF_MV_DEF;
    sat  = (mv > VREF_MV_DEF) || (q >= (longint'(1) << CODE_W_DEF));
    code = (q >= (longint'(1) << CODE_W_DEF)) ? '1 : CODE_W_DEF'(q);
    return {sat, code};
  endfunction

endpackage

// File: rtl/serial_divider.sv
// Generic restoring divider: one quotient bit per clock, DIV_W steps after start.
// Only the low QUO_W quotient bits are kept; callers size QUO_W to the quotient range they need.
module serial_divider #(
  parameter int unsigned DIV_W = 24,
  parameter int unsigned DEN_W = 12,
  parameter int unsigned QUO_W = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DEN_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [QUO_W-1:0] quotient,
  output logic [DEN_W:0]   remainder
);

  localparam int unsigned CNT_W = $clog2(DIV_W + 1);
  localparam logic [CNT_W-1:0] LastStep = CNT_W'(DIV_W - 1);

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] num_q, num_d;
  logic [DEN_W-1:0] den_q, den_d;
  logic [DEN_W:0]   rem_q, rem_d;
  logic [QUO_W-1:0] quo_q, quo_d;

  logic [DEN_W:0]   rem_sh;
  logic             ge;

  // Next-state: load on start when idle, otherwise one shift/subtract step per cycle while busy.
  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    cnt_d  = cnt_q;
    num_d  = num_q;
    den_d  = den_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    // Remainder stays below the divisor, so its top bit is always zero before the shift.
    rem_sh = {rem_q[DEN_W-1:0], num_q[DIV_W-1]};
    ge     = (rem_sh >= {1'b0, den_q});
    if (busy_q) begin
      rem_d = ge ? (rem_sh - {1'b0, den_q}) : rem_sh;
      quo_d = (quo_q << 1) | QUO_W'(ge);
      num_d = num_q << 1;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LastStep) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end else if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      num_d  = dividend;
      den_d  = divisor;
      rem_d  = '0;
      quo_d  = '0;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      num_q  <= '0;
      den_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      num_q  <= num_d;
      den_q  <= den_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/voltage_descaler.sv
// Millivolt to converter-code conversion with round-to-nearest and saturation,
// built around a serial divider behind valid/ready handshakes.
module voltage_descaler
  import voltage_pkg::*;
#(
  parameter int unsigned MV_W    = MV_W_DEF,
  parameter int unsigned CODE_W  = CODE_W_DEF,
  parameter int unsigned VREF_MV = VREF_MV_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [MV_W-1:0]   in_mv,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_sat,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int unsigned NUM_W = MV_W + CODE_W;
  // Wide enough to hold VREF_MV itself, including exact powers of two.
  localparam int unsigned DEN_W = $clog2(VREF_MV + 1);
  localparam logic [MV_W-1:0]  VrefMv  = MV_W'(VREF_MV);
  localparam logic [NUM_W-1:0] HalfRef = NUM_W'(VREF_MV / 2);

  state_e            state_q, state_d;
  logic              sat_req_q, sat_req_d;
  logic [CODE_W-1:0] out_code_q, out_code_d;
  logic              out_sat_q, out_sat_d;

  logic              accept;
  logic [MV_W-1:0]   mv_c;
  logic [NUM_W-1:0]  dividend;
  logic              div_busy;
  logic              div_done;
  logic [CODE_W:0]   div_quo;
  logic [DEN_W:0]    div_rem;
  logic              unused_div;

  assign in_ready  = rst && (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out_code  = out_code_q;
  assign out_sat   = out_sat_q;

  assign accept   = in_valid && (state_q == StIdle);
  assign mv_c     = (in_mv > VrefMv) ? VrefMv : in_mv;
  assign dividend = {mv_c, {CODE_W{1'b0}}} + HalfRef;

  serial_divider #(
    .DIV_W (NUM_W),
    .DEN_W (DEN_W),
    .QUO_W (CODE_W + 1)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (accept),
    .dividend  (dividend),
    .divisor   (DEN_W'(VREF_MV)),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign unused_div = ^{div_busy, div_rem};

  // FSM next-state and result capture; the quotient tops out at exactly 2^CODE_W.
  always_comb begin
    state_d    = state_q;
    sat_req_d  = sat_req_q;
    out_code_d = out_code_q;
    out_sat_d  = out_sat_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          sat_req_d = (in_mv > VrefMv);
          state_d   = StDiv;
        end
      end
      StDiv: begin
        if (div_done) begin
          out_code_d = div_quo[CODE_W] ? {CODE_W{1'b1}} : div_quo[CODE_W-1:0];
          out_sat_d  = sat_req_q | div_quo[CODE_W];
          state_d    = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      sat_req_q  <= 1'b0;
      out_code_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sat_req_q  <= sat_req_d;
      out_code_q <= out_code_d;
      out_sat_q  <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_voltage_descaler.sv
// Self-checking bench for voltage_descaler: directed corner cases plus a randomized sweep
// scored against an arithmetic reference model.
module tb_voltage_descaler;

  localparam int unsigned MV_W    = 12;
  localparam int unsigned CODE_W  = 12;
  localparam int unsigned VREF    = 3300;
  localparam int unsigned LATENCY = MV_W + CODE_W + 1;
  localparam int unsigned N_RAND  = 200;

  logic              clk;
  logic              rst;
  logic [MV_W-1:0]   in_mv;
  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] out_code;
  logic              out_sat;
  logic              out_valid;
  logic              out_ready;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  voltage_descaler #(
    .MV_W    (MV_W),
    .CODE_W  (CODE_W),
    .VREF_MV (VREF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_mv     (in_mv),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_code  (out_code),
    .out_sat   (out_sat),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: round-to-nearest of mv * 2^CODE_W / VREF with clamping.
  function automatic void ref_model(input int unsigned mv, output int unsigned code,
                                    output int unsigned sat);
    longint unsigned m, q, full;
    full = longint'(1) << CODE_W;
    m    = (mv > VREF) ? VREF : mv;
    q    = (m * full + VREF / 2) / VREF;
    sat  = ((mv > VREF) || (q >= full)) ? 1 : 0;
    code = (q >= full) ? int'(full - 1) : int'(q);
  endfunction

  task automatic send(input int unsigned mv);
    int n;
    n = 0;
    @(negedge clk);
    in_mv    = MV_W'(mv);
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!out_valid && lat < 100);
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("post_ack_out_valid", out_valid, 0);
    check("post_ack_in_ready", in_ready, 1);
  endtask

  task automatic run_one(input int unsigned mv);
    int lat;
    int unsigned ec, es;
    ref_model(mv, ec, es);
    send(mv);
    wait_out(lat);
    check($sformatf("latency_mv%0d", mv), lat, LATENCY);
    check($sformatf("code_mv%0d", mv), out_code, ec);
    check($sformatf("sat_mv%0d", mv), out_sat, es);
    release_out();
  endtask

  int unsigned dir_mv[7] = '{0, 1000, 1650, 1, 3299, 3300, 4000};
  int unsigned exp_q[$];
  int unsigned sent, got;

  initial begin
    int lat;
    int unsigned held_code, held_sat, n_vis;
    rst = 1'b0; in_valid = 1'b0; in_mv = '0; out_ready = 1'b0;
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_code", out_code, 0);
    check("rst_out_sat", out_sat, 0);
    @(negedge clk);
    rst = 1'b1;
    #1 check("rel_in_ready", in_ready, 1);

    // Spot-check the hand-computed values from the test plan.
    check("hand_1000", dir_mv[1] == 1000 ? 1241 : 0, 1241);
    foreach (dir_mv[i]) run_one(dir_mv[i]);
    run_one(2500);

    // Back-pressure: results hold, new requests are ignored.
    send(1000);
    wait_out(lat);
    held_code = out_code;
    held_sat  = out_sat;
    check("bp_code", held_code, 1241);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_mv    = 12'd5;
      #1;
      if (out_code != held_code || out_sat != held_sat || !out_valid || in_ready) begin
        check("bp_stable", {out_valid, in_ready, out_sat, out_code},
              {1'b1, 1'b0, held_sat[0], held_code[CODE_W-1:0]});
      end
    end
    check("bp_valid_held", out_valid, 1);
    check("bp_in_ready", in_ready, 0);
    in_valid = 1'b0;
    release_out();
    n_vis = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) n_vis++;
    end
    check("bp_not_queued", n_vis, 0);

    // Reset in the middle of a division.
    send(3000);
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    n_vis = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) n_vis++;
    end
    check("midrst_no_result", n_vis, 0);
    check("midrst_idle", in_ready, 1);
    run_one(2500);

    // Randomized sweep with random input gaps and output back-pressure.
    sent = 0;
    got  = 0;
    fork
      begin : producer
        int unsigned cyc, ec, es, mv;
        cyc = 0;
        while (sent < N_RAND && cyc < 30000) begin
          @(negedge clk);
          cyc++;
          mv       = $urandom_range(0, 4095);
          in_mv    = MV_W'(mv);
          in_valid = ($urandom_range(0, 2) != 0);
          if (in_valid && in_ready) begin
            ref_model(mv, ec, es);
            exp_q.push_back((es << CODE_W) | ec);
            sent++;
          end
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin : consumer
        int unsigned cyc, e, prev;
        logic was_valid;
        cyc = 0;
        was_valid = 1'b0;
        prev = 0;
        while (got < N_RAND && cyc < 32000) begin
          @(negedge clk);
          cyc++;
          if (was_valid && out_valid) begin
            check("rand_hold", {out_sat, out_code}, prev);
          end
          out_ready = ($urandom_range(0, 1) != 0);
          prev      = {out_sat, out_code};
          was_valid = out_valid && !out_ready;
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              check("rand_unexpected", 1, 0);
            end else begin
              e = exp_q.pop_front();
              check("rand_result", {out_sat, out_code}, e);
            end
            got++;
          end
        end
        @(negedge clk);
        out_ready = 1'b0;
      end
    join
    check("rand_sent", sent, N_RAND);
    check("rand_in_eq_out", got, sent);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
